// File: rtl/volume_button_ctrl_pkg.sv
// Shared types and sizing helper for the volume button controller and its debounce sub-blocks.
package volume_btn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD_UP,
    HOLD_DN,
    REPEAT_UP,
    REPEAT_DN,
    LOCK
  } btn_state_e;

  localparam int BtnUp = 0;
  localparam int BtnDn = 1;

  // One counter width is shared by the debounce counters and the hold/repeat timer.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/volume_button_ctrl_if.sv
// Raw button inputs and step-request pulses between the board buttons and the volume block.
interface volume_button_ctrl_if;
  logic up_raw_i;
  logic down_raw_i;
  logic up_o;
  logic down_o;
  logic busy_o;

  modport master (
    input  up_raw_i,
    input  down_raw_i,
    output up_o,
    output down_o,
    output busy_o
  );

  modport slave (
    output up_raw_i,
    output down_raw_i,
    input  up_o,
    input  down_o,
    input  busy_o
  );
endinterface

// File: rtl/volume_button_ctrl_btn_debounce.sv
// Per-button conditioner: 2-flop synchroniser, debounce counter and a registered rising-edge flag.
// The debounced level rises 2+debounce_cycles_p edges after the raw input is first sampled high.
module btn_debounce #(
  parameter int debounce_cycles_p = 16,
  parameter int cnt_w_p           = 5
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam logic [cnt_w_p-1:0] CntLimit = cnt_w_p'(debounce_cycles_p);
  localparam logic [cnt_w_p-1:0] CntOne   = cnt_w_p'(1);

  logic               sync1_reg;
  logic               sync2_reg;
  logic               level_reg;
  logic               rise_reg;
  logic [cnt_w_p-1:0] cnt_reg;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw_i;
      sync2_reg <= sync1_reg;
      rise_reg  <= 1'b0;
      // Any agreeing sample restarts the qualification window, so short bounces vanish.
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg >= CntLimit) begin
        level_reg <= ~level_reg;
        rise_reg  <= ~level_reg;
        cnt_reg   <= '0;
      end else if (cnt_reg != '1) begin
        cnt_reg <= cnt_reg + CntOne;
      end
    end
  end

  assign level_o = level_reg;
  assign rise_o  = rise_reg;

endmodule

// File: rtl/volume_button_ctrl.sv
// Turns two bouncy push-buttons into single-cycle up/down step pulses for the volume block.
// Auto-repeat while held is built only when VOLUME_BTN_AUTOREPEAT_EN is defined.
module volume_button_ctrl
  import volume_btn_pkg::*;
#(
  parameter int debounce_cycles_p = 16,
  parameter int repeat_delay_p    = 64,
  parameter int repeat_period_p   = 16
) (
  input logic clk_i,
  input logic reset_i,
  volume_button_ctrl_if.master btn_if
);

  localparam int CntW = cnt_width(debounce_cycles_p, repeat_delay_p, repeat_period_p);

  logic [1:0] raw_vec;
  logic [1:0] level_vec;
  logic [1:0] rise_vec;

  assign raw_vec[BtnUp] = btn_if.up_raw_i;
  assign raw_vec[BtnDn] = btn_if.down_raw_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      btn_debounce #(
        .debounce_cycles_p(debounce_cycles_p),
        .cnt_w_p          (CntW)
      ) u_debounce (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .raw_i  (raw_vec[gi]),
        .level_o(level_vec[gi]),
        .rise_o (rise_vec[gi])
      );
    end
  endgenerate

  logic up_lvl, dn_lvl, up_rise, dn_rise;
  assign up_lvl  = level_vec[BtnUp];
  assign dn_lvl  = level_vec[BtnDn];
  assign up_rise = rise_vec[BtnUp];
  assign dn_rise = rise_vec[BtnDn];

  btn_state_e state_reg, state_next;
  logic       up_reg, up_next;
  logic       down_reg, down_next;

`ifdef VOLUME_BTN_AUTOREPEAT_EN
  localparam logic [CntW-1:0] DelayLast  = CntW'(repeat_delay_p - 1);
  localparam logic [CntW-1:0] PeriodLast = CntW'(repeat_period_p - 1);
  localparam logic [CntW-1:0] TimerOne   = CntW'(1);

  logic [CntW-1:0] timer_reg, timer_next;
  logic [CntW-1:0] timer_inc;
  assign timer_inc = (timer_reg == '1) ? timer_reg : timer_reg + TimerOne;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
      up_reg    <= 1'b0;
      down_reg  <= 1'b0;
`ifdef VOLUME_BTN_AUTOREPEAT_EN
      timer_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      up_reg    <= up_next;
      down_reg  <= down_next;
`ifdef VOLUME_BTN_AUTOREPEAT_EN
      timer_reg <= timer_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    up_next    = 1'b0;
    down_next  = 1'b0;
`ifdef VOLUME_BTN_AUTOREPEAT_EN
    // The timer only survives while staying in a hold/repeat state; every entry starts from zero.
    timer_next = '0;
`endif
    case (state_reg)
      IDLE: begin
        if (up_rise || dn_rise) begin
          if (up_lvl && dn_lvl) begin
            state_next = LOCK;
          end else if (up_rise) begin
            up_next    = 1'b1;
            state_next = HOLD_UP;
          end else begin
            down_next  = 1'b1;
            state_next = HOLD_DN;
          end
        end
      end
      HOLD_UP: begin
        if (!up_lvl) begin
          state_next = IDLE;
        end else if (dn_lvl) begin
          state_next = LOCK;
`ifdef VOLUME_BTN_AUTOREPEAT_EN
        end else if (timer_reg == DelayLast) begin
          up_next    = 1'b1;
          state_next = REPEAT_UP;
        end else begin
          timer_next = timer_inc;
`endif
        end
      end
      HOLD_DN: begin
        if (!dn_lvl) begin
          state_next = IDLE;
        end else if (up_lvl) begin
          state_next = LOCK;
`ifdef VOLUME_BTN_AUTOREPEAT_EN
        end else if (timer_reg == DelayLast) begin
          down_next  = 1'b1;
          state_next = REPEAT_DN;
        end else begin
          timer_next = timer_inc;
`endif
        end
      end
`ifdef VOLUME_BTN_AUTOREPEAT_EN
      REPEAT_UP: begin
        if (!up_lvl) begin
          state_next = IDLE;
        end else if (dn_lvl) begin
          state_next = LOCK;
        end else if (timer_reg == PeriodLast) begin
          up_next = 1'b1;
        end else begin
          timer_next = timer_inc;
        end
      end
      REPEAT_DN: begin
        if (!dn_lvl) begin
          state_next = IDLE;
        end else if (up_lvl) begin
          state_next = LOCK;
        end else if (timer_reg == PeriodLast) begin
          down_next = 1'b1;
        end else begin
          timer_next = timer_inc;
        end
      end
`endif
      LOCK: begin
        if (!up_lvl && !dn_lvl) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign btn_if.up_o   = up_reg;
  assign btn_if.down_o = down_reg;
  assign btn_if.busy_o = (state_reg != IDLE);

endmodule

// File: tb/tb_volume_button_ctrl.sv
// Randomised and directed check of volume_button_ctrl against a lookback/timestamp reference model.
`timescale 1ns/1ps
module tb_volume_button_ctrl;

  localparam int D     = 4;
  localparam int DELAY = 20;
  localparam int PER   = 5;
  localparam int MAXC  = 32768;
`ifdef VOLUME_BTN_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  volume_button_ctrl_if bif();

  volume_button_ctrl #(
    .debounce_cycles_p(D),
    .repeat_delay_p   (DELAY),
    .repeat_period_p  (PER)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .btn_if (bif)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state: raw history per button, accepted levels, and a mode with press timestamp.
  bit raw_h [2][MAXC];
  int last_rst = -100;
  bit m_lvl [2];
  bit m_rise[2];
  int m_lc  [2];
  int mode       = 0;   // 0 idle, 1 held up, 2 held down, 3 locked
  int press_edge = 0;
  bit exp_up = 0, exp_dn = 0, exp_busy = 0;
  bit started = 0;
  bit lu, ld, ru, rd, held, other, all_diff;

  int up_q[$];
  int dn_q[$];

  function automatic bit seen(int b, int n);
    if (n - 2 <= last_rst || n - 2 < 1) return 1'b0;
    return raw_h[b][n-2];
  endfunction

  function automatic bit repeat_due(int age);
    return (age == DELAY) || (age > DELAY && ((age - DELAY) % PER) == 0);
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    raw_h[0][cyc] = bif.up_raw_i;
    raw_h[1][cyc] = bif.down_raw_i;
    if (rst) begin
      started  = 1'b1;
      last_rst = cyc;
      mode     = 0;
      exp_up   = 1'b0;
      exp_dn   = 1'b0;
      exp_busy = 1'b0;
      for (int b = 0; b < 2; b++) begin
        m_lvl[b]  = 1'b0;
        m_rise[b] = 1'b0;
        m_lc[b]   = cyc;
      end
    end else begin
      lu = m_lvl[0]; ld = m_lvl[1]; ru = m_rise[0]; rd = m_rise[1];
      exp_up = 1'b0;
      exp_dn = 1'b0;
      case (mode)
        0: if (ru || rd) begin
             if (lu && ld) mode = 3;
             else if (ru) begin exp_up = 1'b1; mode = 1; press_edge = cyc; end
             else begin exp_dn = 1'b1; mode = 2; press_edge = cyc; end
           end
        1, 2: begin
          held  = (mode == 1) ? lu : ld;
          other = (mode == 1) ? ld : lu;
          if (!held) mode = 0;
          else if (other) mode = 3;
          else if (AUTO && repeat_due(cyc - press_edge)) begin
            if (mode == 1) exp_up = 1'b1; else exp_dn = 1'b1;
          end
        end
        default: if (!lu && !ld) mode = 0;
      endcase
      exp_busy = (mode != 0);
      // A level is accepted once the last D+1 synced samples since the previous change all disagree.
      for (int b = 0; b < 2; b++) begin
        m_rise[b] = 1'b0;
        if (cyc - D > m_lc[b]) begin
          all_diff = 1'b1;
          for (int k = 0; k <= D; k++)
            if (seen(b, cyc - k) == m_lvl[b]) all_diff = 1'b0;
          if (all_diff) begin
            m_lvl[b]  = ~m_lvl[b];
            m_rise[b] = m_lvl[b];
            m_lc[b]   = cyc;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checks = checks + 1;
      if ({bif.up_o, bif.down_o, bif.busy_o} !== {exp_up, exp_dn, exp_busy}) begin
        errors = errors + 1;
        $display("FAIL model_cycle %0d: up/down/busy got %b%b%b expected %b%b%b",
                 cyc, bif.up_o, bif.down_o, bif.busy_o, exp_up, exp_dn, exp_busy);
      end
      if (bif.up_o === 1'b1) begin
        up_q.push_back(cyc);
        $display("cycle %0d: up_o pulse", cyc);
      end
      if (bif.down_o === 1'b1) begin
        dn_q.push_back(cyc);
        $display("cycle %0d: down_o pulse", cyc);
      end
    end
  end

  function automatic int count_in(int q[$], int lo, int hi);
    int n = 0;
    foreach (q[i]) if (q[i] >= lo && q[i] <= hi) n++;
    return n;
  endfunction

  function automatic int nth_from(int q[$], int lo, int k);
    int n = 0;
    foreach (q[i]) if (q[i] >= lo) begin
      if (n == k) return q[i];
      n++;
    end
    return -1;
  endfunction

  task automatic check(string name, int got, int want);
    checks = checks + 1;
    if (got != want) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(bit u, bit d);
    bif.up_raw_i   = u;
    bif.down_raw_i = d;
  endtask

  task automatic bounce(bit on_up, bit on_dn, int n);
    for (int i = 0; i < n; i++) begin
      if (on_up) bif.up_raw_i   = 1'($urandom_range(0, 1));
      if (on_dn) bif.down_raw_i = 1'($urandom_range(0, 1));
      tick(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t, t2, r, s, kind;
    bit u;
    set_btn(1'b0, 1'b0);
    rst = 1'b1;
    tick(3);
    check("reset_up_o", int'(bif.up_o), 0);
    check("reset_down_o", int'(bif.down_o), 0);
    check("reset_busy_o", int'(bif.busy_o), 0);
    rst = 1'b0;
    tick(5);

    $display("bounce burst on up_raw_i");
    s = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      set_btn(1'b1, 1'b0); tick(2);
      set_btn(1'b0, 1'b0); tick(2);
    end
    tick(20);
    check("bounce_up_pulses", count_in(up_q, s, cyc), 0);
    check("bounce_down_pulses", count_in(dn_q, s, cyc), 0);

    $display("clean up press held 10 cycles");
    set_btn(1'b1, 1'b0); t = cyc + 1;
    tick(10);
    check("press_busy_held", int'(bif.busy_o), 1);
    set_btn(1'b0, 1'b0);
    tick(25);
    check("press_first_pulse", nth_from(up_q, t, 0), t + 7);
    check("press_pulse_count", count_in(up_q, t, cyc), 1);
    check("press_down_count", count_in(dn_q, t, cyc), 0);
    check("press_busy_released", int'(bif.busy_o), 0);

    $display("down held 60 cycles");
    set_btn(1'b0, 1'b1); t = cyc + 1;
    tick(60);
    set_btn(1'b0, 1'b0);
    tick(25);
    check("hold_first_pulse", nth_from(dn_q, t, 0), t + 7);
    if (AUTO) begin
      check("hold_second_pulse", nth_from(dn_q, t, 1), t + 27);
      check("hold_third_pulse", nth_from(dn_q, t, 2), t + 32);
      check("hold_pulse_count", count_in(dn_q, t, cyc), 9);
    end else begin
      check("hold_pulse_count", count_in(dn_q, t, cyc), 1);
    end

    $display("up held, down joins at hold cycle 10");
    set_btn(1'b1, 1'b0); t = cyc + 1;
    tick(10);
    set_btn(1'b1, 1'b1);
    tick(30);
    set_btn(1'b0, 1'b0);
    tick(25);
    check("lock_up_count", count_in(up_q, t, cyc), 1);
    check("lock_down_count", count_in(dn_q, t, cyc), 0);
    check("lock_busy_released", int'(bif.busy_o), 0);
    set_btn(1'b1, 1'b0); t2 = cyc + 1;
    tick(10);
    set_btn(1'b0, 1'b0);
    tick(25);
    check("repress_first_pulse", nth_from(up_q, t2, 0), t2 + 7);

    $display("both buttons on the same edge");
    set_btn(1'b1, 1'b1); t = cyc + 1;
    tick(15);
    check("both_busy_locked", int'(bif.busy_o), 1);
    tick(15);
    set_btn(1'b0, 1'b0);
    tick(25);
    check("both_pulse_count", count_in(up_q, t, cyc) + count_in(dn_q, t, cyc), 0);
    check("both_busy_released", int'(bif.busy_o), 0);

    $display("reset while up is held");
    set_btn(1'b1, 1'b0); t = cyc + 1;
    tick(35);
    rst = 1'b1; r = cyc + 1;
    tick(1);
    check("midreset_up_o", int'(bif.up_o), 0);
    check("midreset_busy_o", int'(bif.busy_o), 0);
    rst = 1'b0;
    tick(40);
    set_btn(1'b0, 1'b0);
    tick(25);
    check("after_reset_first_pulse", nth_from(up_q, r, 0), r + 8);
    if (AUTO) check("after_reset_repeat", nth_from(up_q, r, 1), r + 28);

    $display("random phase");
    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(0, 5));
      case (kind)
        0, 1: begin
          u = (kind == 0);
          bounce(u, !u, int'($urandom_range(0, 6)));
          set_btn(u, !u); tick(int'($urandom_range(5, 70)));
          bounce(u, !u, int'($urandom_range(0, 6)));
          set_btn(1'b0, 1'b0); tick(int'($urandom_range(0, 30)));
        end
        2: begin
          u = 1'($urandom_range(0, 1));
          set_btn(u, !u); tick(int'($urandom_range(0, 30)));
          set_btn(1'b1, 1'b1); tick(int'($urandom_range(1, 40)));
          u = 1'($urandom_range(0, 1));
          set_btn(u, !u); tick(int'($urandom_range(0, 10)));
          set_btn(1'b0, 1'b0); tick(int'($urandom_range(0, 20)));
        end
        3: begin
          set_btn(1'b0, 1'b0); tick(int'($urandom_range(5, 40)));
        end
        4: begin
          u = 1'($urandom_range(0, 1));
          set_btn(u, !u); tick(int'($urandom_range(1, D)));
          set_btn(1'b0, 1'b0); tick(int'($urandom_range(0, 10)));
        end
        default: begin
          set_btn(1'b1, 1'b0); tick(int'($urandom_range(10, 50)));
          rst = 1'b1; tick(int'($urandom_range(1, 2)));
          rst = 1'b0; tick(int'($urandom_range(0, 40)));
          set_btn(1'b0, 1'b0); tick(20);
        end
      endcase
    end
    set_btn(1'b0, 1'b0);
    tick(30);
    check("final_busy_idle", int'(bif.busy_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
